// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned OP_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // ALU control codes; the arbiter forwards them untouched.
  localparam logic [3:0] OP_MOV0  = 4'h0;
  localparam logic [3:0] OP_MOV1  = 4'h1;
  localparam logic [3:0] OP_MOV2  = 4'h2;
  localparam logic [3:0] OP_MOV3  = 4'h3;
  localparam logic [3:0] OP_SLL   = 4'h4;
  localparam logic [3:0] OP_SRL   = 4'h5;
  localparam logic [3:0] OP_SRA   = 4'h6;
  localparam logic [3:0] OP_ROL   = 4'h7;
  localparam logic [3:0] OP_ROR   = 4'h8;
  localparam logic [3:0] OP_NOT   = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_OR    = 4'hB;
  localparam logic [3:0] OP_AND   = 4'hC;
  localparam logic [3:0] OP_SUB   = 4'hD;
  localparam logic [3:0] OP_ADD   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way grant for alu_arb. Round-robin by default; ALU_ARB_FIXED_PRIO_EN
// selects fixed priority for requester 0 and drops the last-grant state.
module alu_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic hs,
  output logic gnt0_c,
  output logic gnt1_c
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_c;
  assign unused_c = ^{clk, rst_n, hs};

  assign gnt0_c = req0;
  assign gnt1_c = req1 & ~req0;
`else
  // 1 means requester 1 was granted last, so requester 0 wins after reset.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (hs) begin
      last_q <= gnt1_c;
    end
  end

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (req0 && req1) begin
      gnt0_c = last_q;
      gnt1_c = ~last_q;
    end else begin
      gnt0_c = req0;
      gnt1_c = req1;
    end
  end
`endif

endmodule

// File: rtl/alu_arb.sv
// Shares one combinational ALU between two requesters, one op in flight.
// Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
);

  state_t            state;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;
  logic              rsp_id_q;
  logic              rsp_valid_q;
  logic              idle_c;
  logic              gnt0_c;
  logic              gnt1_c;
  logic              hs_c;

  // Grants only exist in IDLE and out of reset.
  assign idle_c = (state == IDLE) && rst_n;

  alu_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0_valid & idle_c),
    .req1   (req1_valid & idle_c),
    .hs     (hs_c),
    .gnt0_c (gnt0_c),
    .gnt1_c (gnt1_c)
  );

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;
  assign hs_c       = gnt0_c | gnt1_c;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = res_q;
  assign rsp_id    = rsp_id_q;

  // rsp_id has its own register so it keeps the last result's id after a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      res_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs_c) begin
            a_q   <= gnt1_c ? req1_a : req0_a;
            b_q   <= gnt1_c ? req1_b : req0_b;
            op_q  <= gnt1_c ? req1_op : req0_op;
            id_q  <= gnt1_c;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_q       <= alu_out;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Randomized bench for alu_arb against a transaction-level model of the arbiter.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_out, rsp_data;
  logic [3:0]  alu_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id;

  always #5 clk = ~clk;

  alu_arb #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  // Behavioural ALU used both as the environment and for expected results.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    int unsigned s;
    s = int'(b[4:0]);
    case (op)
      OP_SLL:   return a << s;
      OP_SRL:   return a >> s;
      OP_SRA:   return $unsigned($signed(a) >>> s);
      OP_ROL:   return (a << s) | (a >> (32 - s));
      OP_ROR:   return (a >> s) | (a << (32 - s));
      OP_NOT:   return ~a;
      OP_XOR:   return a ^ b;
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_SUB:   return b - a;
      OP_ADD:   return a + b;
      OP_PASSB: return b;
      default:  return a;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_ctrl);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester side: pending requests held until accepted.
  bit          rv  [2];
  logic [31:0] ra  [2];
  logic [31:0] rb  [2];
  logic [3:0]  rop [2];

  // Model: one op in flight, response two cycles after accept.
  bit          in_flight;
  int          acc_cyc;
  int          cyc;
  int          last_gnt;
  logic [31:0] exp_data, last_data;
  logic        exp_id, last_id;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  int          gnt_log[$];

  function automatic int exp_grant();
    if (in_flight) return -1;
    if (rv[0] && rv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_gnt == 0) ? 1 : 0;
`endif
    end
    if (rv[0]) return 0;
    if (rv[1]) return 1;
    return -1;
  endfunction

  task automatic drive();
    req0_valid = rv[0]; req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0];
    req1_valid = rv[1]; req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1];
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    rv[i] = 1'b1; ra[i] = a; rb[i] = b; rop[i] = op;
  endtask

  task automatic model_reset();
    in_flight = 1'b0; last_gnt = 1;
    last_data = '0; last_id = 1'b0; exp_data = '0; exp_id = 1'b0;
    m_a = '0; m_b = '0; m_op = '0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit rdy);
    int  g;
    bit  ev;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();
    rsp_ready = rdy;
    #1;
    g  = exp_grant();
    ev = in_flight && (cyc >= acc_cyc + 2);
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("rsp_valid", rsp_valid, ev);
    check("rsp_data", rsp_data, ev ? exp_data : last_data);
    check("rsp_id", rsp_id, ev ? exp_id : last_id);
    check("alu_ops", {alu_a, alu_b, alu_ctrl}, {m_a, m_b, m_op});
    if (req0_ready) gnt_log.push_back(0);
    if (req1_ready) gnt_log.push_back(1);
    if (ev && rdy) begin
      in_flight = 1'b0; last_data = exp_data; last_id = exp_id;
    end
    if (g >= 0) begin
      in_flight = 1'b1; acc_cyc = cyc; last_gnt = g;
      exp_data = alu_fn(ra[g], rb[g], rop[g]); exp_id = 1'(g);
      m_a = ra[g]; m_b = rb[g]; m_op = rop[g];
      rv[g] = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive();
    #1;
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 34'd0);
    check("rst_alu", {alu_a, alu_b, alu_ctrl}, 68'd0);
    @(posedge clk);
    model_reset();
  endtask

  task automatic rand_req(input int pct);
    for (int i = 0; i < 2; i++)
      if (!rv[i] && ($urandom_range(0, 99) < pct))
        set_req(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; cyc = 0; acc_cyc = 0;
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rop[i] = '0; end
    model_reset();
    drive();
    do_reset();

    // Basic add from requester 0.
    set_req(0, 32'd5, 32'd7, OP_ADD);
    step(1'b1);
    check("s1_ready0", req0_ready, 1'b1);
    step(1'b1);
    step(1'b1);
    check("s1_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 32'd12});

    // Both requesters always valid: grant sequence.
    do_reset();
    gnt_log.delete();
    for (int c = 0; c < 12; c++) begin rand_req(100); step(1'b1); end
    check("s2_ngrants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("s2_grant", gnt_log[i], 0);
`else
      check("s2_grant", gnt_log[i], i % 2);
`endif
    end

    // Held response; requester 0 waits while the result is stalled.
    rv[0] = 1'b0; rv[1] = 1'b0;
    do_reset();
    set_req(1, 32'd3, 32'd10, OP_SUB);
    step(1'b0);
    check("s3_ready1", req1_ready, 1'b1);
    set_req(0, 32'h11, 32'h22, OP_XOR);
    step(1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0);
      check("s3_hold", {rsp_valid, rsp_data, req0_ready, req1_ready}, {1'b1, 32'd7, 2'b00});
    end
    step(1'b1);
    check("s6_ready0_resp", req0_ready, 1'b0);
    step(1'b1);
    check("s6_ready0_idle", req0_ready, 1'b1);
    check("s3_retain", {rsp_valid, rsp_data}, {1'b0, 32'd7});
    step(1'b1); step(1'b1);

    // Subtract wrap-around.
    set_req(1, 32'd1, 32'd0, OP_SUB);
    step(1'b1); step(1'b1); step(1'b1);
    check("s4_wrap", {rsp_valid, rsp_data}, {1'b1, 32'hFFFF_FFFF});

    // Reset during EXEC drops the op; requester 0 wins afterwards.
    set_req(0, $urandom, $urandom, OP_AND);
    step(1'b0);
    set_req(0, $urandom, $urandom, OP_OR);
    set_req(1, $urandom, $urandom, OP_ADD);
    do_reset();
    step(1'b0);
    check("s5_post_rst", {rsp_valid, req0_ready, req1_ready}, 3'b010);
    for (int c = 0; c < 4; c++) step(1'b1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rand_req(60);
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < 70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
